sdnet_to_mtpsa: RTL and testbench

//  Output-side adapter from the SDNet user switch back to the SUME AXI-Stream fabric; it is the counterpart of mtpsa_to_sdnet.

---
 rtl/sdnet_to_mtpsa_pkg.sv | 20 ++
 rtl/sdnet_to_mtpsa_tuple_fifo.sv | 55 +++++
 rtl/sdnet_to_mtpsa.sv | 155 +++++++++++++++
 tb/tb_sdnet_to_mtpsa.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdnet_to_mtpsa_pkg.sv
// Shared types and constants for the SDNet -> SUME output adapter.
package sdnet_to_mtpsa_pkg;

   // Packet FSM: IDLE waits for a first beat with a queued tuple; PKT carries the held tuple
   typedef enum logic {
      IDLE = 1'b0,
      PKT  = 1'b1
   } state_t;

   // Field offsets inside the metadata tuple (low bits of m_axis_tuser)
   localparam int PKT_LEN_LSB  = 0;
   localparam int SRC_PORT_LSB = 16;
   localparam int DST_PORT_LSB = 24;
   localparam int SEND_DIG_LSB = 32;

   // Default tuple widths produced by the SDNet user switch
   localparam int SDNET_TUPLE_WIDTH  = 40;
   localparam int SDNET_DIGEST_WIDTH = 256;

endpackage

// File: rtl/sdnet_to_mtpsa_tuple_fifo.sv
// Synchronous FIFO holding {digest, meta} tuples until their packet starts.
// A push into a full FIFO is accepted only when a pop happens in the same cycle;
// otherwise it is dropped and reported on drop for one cycle.
module sdnet_to_mtpsa_tuple_fifo #(
   parameter int WIDTH = 296,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic                       drop,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign drop    = push && full && !do_pop;
   // Head is read straight from storage; a fresh push is never visible before the next cycle
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Tuple storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sdnet_to_mtpsa.sv
// Output adapter from the SDNet user switch to the SUME AXI-Stream fabric.
// Queues per-packet tuples, stamps the head tuple on every beat of its packet
// as m_axis_tuser, and re-times the stream through a 2-entry skid buffer.
// Optional: define SDNET_TO_MTPSA_STATS_EN to add pkt_count / tuple_drop_count.
module sdnet_to_mtpsa
   import sdnet_to_mtpsa_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH = 256,
   parameter int TUPLE_WIDTH       = SDNET_TUPLE_WIDTH,
   parameter int DIGEST_WIDTH      = SDNET_DIGEST_WIDTH,
   parameter int TUPLE_FIFO_DEPTH  = 4
) (
   input  logic                                  axis_aclk,
   input  logic                                  axis_resetn,
   input  logic [C_AXIS_DATA_WIDTH-1:0]          s_sdnet_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]        s_sdnet_tkeep,
   input  logic                                  s_sdnet_tvalid,
   output logic                                  s_sdnet_tready,
   input  logic                                  s_sdnet_tlast,
   input  logic                                  tuple_valid,
   input  logic [TUPLE_WIDTH-1:0]                tuple_meta,
   input  logic [DIGEST_WIDTH-1:0]               tuple_digest,
   output logic [C_AXIS_DATA_WIDTH-1:0]          m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]        m_axis_tkeep,
   output logic [DIGEST_WIDTH+TUPLE_WIDTH-1:0]   m_axis_tuser,
   output logic                                  m_axis_tvalid,
   input  logic                                  m_axis_tready,
   output logic                                  m_axis_tlast,
   output logic                                  tuple_overflow,
   output logic [$clog2(TUPLE_FIFO_DEPTH):0]     tuple_fifo_count
`ifdef SDNET_TO_MTPSA_STATS_EN
   ,
   output logic [31:0]                           pkt_count,
   output logic [15:0]                           tuple_drop_count
`endif
);

   localparam int KW = C_AXIS_DATA_WIDTH / 8;
   localparam int UW = DIGEST_WIDTH + TUPLE_WIDTH;

   typedef struct packed {
      logic [C_AXIS_DATA_WIDTH-1:0] data;
      logic [KW-1:0]                keep;
      logic [UW-1:0]                user;
      logic                         last;
   } beat_t;

   state_t          state;
   state_t          state_n;
   logic [UW-1:0]   cur_tuser;
   logic [UW-1:0]   fifo_head;
   logic            fifo_empty;
   logic            fifo_full;
   logic            fifo_drop;
   logic            fifo_pop;
   logic            s_acc;
   logic            m_pop;
   beat_t           in_beat;
   beat_t           skid0;
   beat_t           skid1;
   logic [1:0]      skid_cnt;

   sdnet_to_mtpsa_tuple_fifo #(
      .WIDTH (UW),
      .DEPTH (TUPLE_FIFO_DEPTH)
   ) u_tuple_fifo (
      .clk   (axis_aclk),
      .rst_n (axis_resetn),
      .push  (tuple_valid),
      .din   ({tuple_digest, tuple_meta}),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .drop  (fifo_drop),
      .count (tuple_fifo_count)
   );

   // Input ready depends only on registered state so m_axis_tready never reaches s_sdnet_tready
   assign s_sdnet_tready = (skid_cnt != 2'd2) && !((state == IDLE) && fifo_empty);
   assign s_acc          = s_sdnet_tvalid && s_sdnet_tready;
   assign fifo_pop       = s_acc && (state == IDLE);
   assign m_pop          = m_axis_tvalid && m_axis_tready;

   // The first beat takes the FIFO head directly; later beats reuse the latched copy
   assign in_beat.data = s_sdnet_tdata;
   assign in_beat.keep = s_sdnet_tkeep;
   assign in_beat.user = (state == IDLE) ? fifo_head : cur_tuser;
   assign in_beat.last = s_sdnet_tlast;

   assign m_axis_tvalid = (skid_cnt != 2'd0);
   assign m_axis_tdata  = skid0.data;
   assign m_axis_tkeep  = skid0.keep;
   assign m_axis_tuser  = skid0.user;
   assign m_axis_tlast  = skid0.last;

   // FSM state register and tuple latched at packet start
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state     <= IDLE;
         cur_tuser <= '0;
      end else begin
         state <= state_n;
         if (fifo_pop) cur_tuser <= fifo_head;
      end
   end

   // Next state: single-beat packets keep the FSM in IDLE
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (s_acc && !s_sdnet_tlast) state_n = PKT;
         PKT:     if (s_acc && s_sdnet_tlast)  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Skid buffer: slot0 drives m_axis_*, slot1 catches the beat accepted while slot0 stalls
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         skid0    <= '0;
         skid1    <= '0;
         skid_cnt <= 2'd0;
      end else begin
         if (m_pop)
            skid0 <= (skid_cnt == 2'd2) ? skid1 : in_beat;
         else if (s_acc && (skid_cnt == 2'd0))
            skid0 <= in_beat;
         if (s_acc && !m_pop && (skid_cnt == 2'd1))
            skid1 <= in_beat;
         skid_cnt <= skid_cnt + {1'b0, s_acc} - {1'b0, m_pop};
      end
   end

   // Sticky record of any tuple lost to a full FIFO
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn)   tuple_overflow <= 1'b0;
      else if (fifo_drop) tuple_overflow <= 1'b1;
   end

`ifdef SDNET_TO_MTPSA_STATS_EN
   // Packet counter wraps; drop counter saturates
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         pkt_count        <= '0;
         tuple_drop_count <= '0;
      end else begin
         if (m_pop && skid0.last) pkt_count <= pkt_count + 32'd1;
         if (fifo_drop && (tuple_drop_count != 16'hFFFF))
            tuple_drop_count <= tuple_drop_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sdnet_to_mtpsa.sv
// Scoreboard bench for sdnet_to_mtpsa: expected beats are queued as the input
// side hands them over and retired as the output side delivers them.
module tb_sdnet_to_mtpsa;
   import sdnet_to_mtpsa_pkg::*;

   localparam int DW = 256, KW = 32, TW = 40, GW = 256, UW = 296, DEPTH = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [DW-1:0]  s_tdata;
   logic [KW-1:0]  s_tkeep;
   logic           s_tvalid, s_tready, s_tlast;
   logic           tuple_valid;
   logic [TW-1:0]  tuple_meta;
   logic [GW-1:0]  tuple_digest;
   logic [DW-1:0]  m_tdata;
   logic [KW-1:0]  m_tkeep;
   logic [UW-1:0]  m_tuser;
   logic           m_tvalid, m_tready, m_tlast;
   logic           ovf;
   logic [2:0]     cnt;
`ifdef SDNET_TO_MTPSA_STATS_EN
   logic [31:0]    pkt_count;
   logic [15:0]    drop_count;
`endif

   sdnet_to_mtpsa dut (
      .axis_aclk        (clk),
      .axis_resetn      (rst_n),
      .s_sdnet_tdata    (s_tdata),
      .s_sdnet_tkeep    (s_tkeep),
      .s_sdnet_tvalid   (s_tvalid),
      .s_sdnet_tready   (s_tready),
      .s_sdnet_tlast    (s_tlast),
      .tuple_valid      (tuple_valid),
      .tuple_meta       (tuple_meta),
      .tuple_digest     (tuple_digest),
      .m_axis_tdata     (m_tdata),
      .m_axis_tkeep     (m_tkeep),
      .m_axis_tuser     (m_tuser),
      .m_axis_tvalid    (m_tvalid),
      .m_axis_tready    (m_tready),
      .m_axis_tlast     (m_tlast),
      .tuple_overflow   (ovf),
      .tuple_fifo_count (cnt)
`ifdef SDNET_TO_MTPSA_STATS_EN
      ,
      .pkt_count        (pkt_count),
      .tuple_drop_count (drop_count)
`endif
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic [UW-1:0] user;
      int            cyc;
   } exp_t;

   exp_t            exp_q[$];
   logic [UW-1:0]   tq[$];
   exp_t            e;
   logic [UW-1:0]   cur_user;
   logic [DW+KW+1:0] prev_bus;
   logic [UW-1:0]   prev_user;
   int              n_vec = 0, n_bad = 0, cyc = 0, m_outs = 0, rdy_mode = 0;
   bit              in_pkt = 0, lat_chk = 0, prev_stall = 0, popped = 0;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [TW-1:0] mk_meta(input logic [15:0] len, input logic [7:0] src,
                                             input logic [7:0] dst, input logic [7:0] sd);
      logic [TW-1:0] m;
      m = '0;
      m[PKT_LEN_LSB  +: 16] = len;
      m[SRC_PORT_LSB +: 8]  = src;
      m[DST_PORT_LSB +: 8]  = dst;
      m[SEND_DIG_LSB +: 8]  = sd;
      return m;
   endfunction

   task automatic send_tuple(input logic [TW-1:0] meta, input logic [GW-1:0] dig);
      tuple_valid  = 1'b1;
      tuple_meta   = meta;
      tuple_digest = dig;
      tick();
      tuple_valid  = 1'b0;
   endtask

   // Drives n beats; waits = cycles the first beat sat unaccepted
   task automatic send_pkt(input int n, input int base, input bit no_last, output int waits);
      waits = 0;
      for (int i = 0; i < n; i++) begin
         int w;
         bit ok;
         w  = 0;
         ok = 1'b0;
         s_tvalid = 1'b1;
         s_tdata  = {8{32'(base + i)}};
         s_tkeep  = (i == n - 1) ? 32'h0000_FFFF : '1;
         s_tlast  = (i == n - 1) && !no_last;
         while (!ok && w < 200) begin
            @(negedge clk);
            ok = s_tready;
            tick();
            if (!ok) w++;
         end
         if (!ok) chk("accept_timeout", 0, 1);
         if (i == 0) waits = w;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 300) begin
         tick();
         w++;
      end
      chk("drain", exp_q.size(), 0);
      repeat (2) tick();
   endtask

   // Sink ready pattern: 0 = always ready, 1 = toggling, other = stalled
   initial begin
      m_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = !m_tready;
            default: m_tready = 1'b0;
         endcase
      end
   end

   // Reference model and scoreboard, evaluated mid-cycle with all signals settled
   always @(negedge clk) begin
      if (rst_n) begin
         cyc++;
         if (!in_pkt && tq.size() == 0) chk("rdy_empty", s_tready, 0);
         popped = 1'b0;
         if (s_tvalid && s_tready) begin
            if (!in_pkt) begin
               if (tq.size() == 0) chk("tuple_avail", 0, 1);
               else begin
                  cur_user = tq.pop_front();
                  popped   = 1'b1;
               end
            end
            exp_q.push_back('{s_tdata, s_tkeep, s_tlast, cur_user, cyc});
            in_pkt = !s_tlast;
         end
         if (tuple_valid && !(tq.size() == DEPTH && !popped))
            tq.push_back({tuple_digest, tuple_meta});
         if (prev_stall) begin
            chk("hold_bus", {m_tvalid, m_tlast, m_tkeep, m_tdata}, prev_bus);
            chk("hold_user", m_tuser, prev_user);
         end
         prev_stall = m_tvalid && !m_tready;
         prev_bus   = {m_tvalid, m_tlast, m_tkeep, m_tdata};
         prev_user  = m_tuser;
         if (m_tvalid && m_tready) begin
            m_outs++;
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("data", m_tdata, e.data);
               chk("keep_last", {m_tkeep, m_tlast}, {e.keep, e.last});
               chk("user", m_tuser, e.user);
               if (lat_chk) chk("latency", 512'(cyc - e.cyc), 1);
            end
         end
      end
   end

   initial begin
      int w, outs0;
      s_tvalid = 0; s_tlast = 0; s_tdata = '0; s_tkeep = '0;
      tuple_valid = 0; tuple_meta = '0; tuple_digest = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tready", s_tready, 0);
      chk("rst_count", cnt, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_tdata", m_tdata, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1: tuple 3 cycles ahead of a 4-beat packet, sink always ready
      lat_chk = 1;
      send_tuple(40'h01_04_01_0100, {8{32'hD16E_0001}});
      repeat (2) tick();
      send_pkt(4, 'h100, 0, w);
      drain();
      lat_chk = 0;
`ifdef SDNET_TO_MTPSA_STATS_EN
      chk("t1_pkt_count", pkt_count, 1);
`endif

      // 2: first beat waits on an empty FIFO; tuple lands at posedge 6, accept at posedge 7
      fork
         send_pkt(1, 'h200, 0, w);
         begin
            repeat (5) tick();
            send_tuple(mk_meta(16'h0040, 8'h02, 8'h08, 8'h00), {8{32'hD16E_0002}});
         end
      join
      chk("t2_wait", w, 6);
      drain();

      // 3: 8 beats under a toggling sink
      send_tuple(mk_meta(16'h0100, 8'h04, 8'h01, 8'h01), {8{32'hD16E_0003}});
      outs0 = m_outs;
      rdy_mode = 1;
      send_pkt(8, 'h300, 0, w);
      drain();
      rdy_mode = 0;
      tick();
      chk("t3_beats", m_outs - outs0, 8);

      // 4: five tuples into a depth-4 FIFO, then four packets
      for (int i = 1; i <= 5; i++)
         send_tuple(mk_meta(16'(i * 64), 8'(i), 8'(8 - i), 8'h00), {8{32'(32'hA000_0000 + i)}});
      tick();
      chk("t4_count", cnt, 4);
      chk("t4_ovf", ovf, 1);
`ifdef SDNET_TO_MTPSA_STATS_EN
      chk("t4_drops", drop_count, 1);
`endif
      for (int i = 0; i < 4; i++) send_pkt(2, 'h400 + 16 * i, 0, w);
      drain();
      chk("t4_count_after", cnt, 0);

      // 5: six single-beat packets back-to-back; two tuples refill a full FIFO while it drains
      lat_chk = 1;
      for (int i = 0; i < 4; i++)
         send_tuple(mk_meta(16'h0020, 8'(16 + i), 8'h01, 8'h00), {8{32'(32'hB000_0000 + i)}});
      fork
         for (int i = 0; i < 6; i++) begin
            int wi;
            send_pkt(1, 'h500 + i, 0, wi);
            chk("t5_wait", wi, 0);
         end
         for (int i = 4; i < 6; i++)
            send_tuple(mk_meta(16'h0020, 8'(16 + i), 8'h01, 8'h00), {8{32'(32'hB000_0000 + i)}});
      join
      drain();
      lat_chk = 0;
      chk("t5_ovf_sticky", ovf, 1);
`ifdef SDNET_TO_MTPSA_STATS_EN
      chk("t5_drops", drop_count, 1);
`endif

      // 6: reset in the middle of a packet
      send_tuple(mk_meta(16'h0080, 8'h01, 8'h02, 8'h00), {8{32'hD16E_0006}});
      tick();
      send_pkt(2, 'h600, 1, w);
      rst_n = 1'b0;
      #1;
      chk("t6_tvalid", m_tvalid, 0);
      chk("t6_count", cnt, 0);
      chk("t6_ovf", ovf, 0);
`ifdef SDNET_TO_MTPSA_STATS_EN
      chk("t6_pkt_count", pkt_count, 0);
`endif
      exp_q.delete();
      tq.delete();
      in_pkt = 0;
      prev_stall = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      fork
         send_pkt(1, 'h700, 0, w);
         begin
            repeat (3) tick();
            send_tuple(mk_meta(16'h0010, 8'h03, 8'h04, 8'h00), {8{32'hD16E_0007}});
         end
      join
      chk("t6_wait", w, 4);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
